// File: rtl/button_pulse_conditioner.sv
// Two-channel push-button front end: 2-FF synchronizer, counter-based debounce FSM and
// single-cycle press pulse per key, plus a debounced held level for each key.
module button_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic key_up,
    input  logic key_down,
    output logic UP,
    output logic DOWN,
    output logic up_held,
    output logic down_held
);

    localparam int unsigned NumCh = 2;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntZero = '0;
    // Raw level of a released key; the synchronizer parks here under reset.
    localparam logic [NumCh-1:0] IdleLevel = {NumCh{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StHeld        = 2'd2,
        StReleaseWait = 2'd3
    } state_e;

    // Channel 0 is the up key, channel 1 the down key.
    logic [NumCh-1:0] raw;
    logic [NumCh-1:0] meta_q;
    logic [NumCh-1:0] sync_q;
    logic [NumCh-1:0] pressed;

    state_e           state_q [NumCh];
    state_e           state_d [NumCh];
    logic [CNT_W-1:0] cnt_q   [NumCh];
    logic [CNT_W-1:0] cnt_d   [NumCh];
    logic [NumCh-1:0] pulse_q;
    logic [NumCh-1:0] pulse_d;
    logic [NumCh-1:0] held;

    assign raw = {key_down, key_up};

    // Synchronizer
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= IdleLevel;
            sync_q <= IdleLevel;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync_q : sync_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NumCh; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= CntZero;
            end
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic; a release is checked before the count so a glitch always wins.
    always_comb begin
        for (int i = 0; i < NumCh; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (pressed[i]) begin
                        state_d[i] = StPressWait;
                        cnt_d[i]   = CntOne;
                    end else begin
                        cnt_d[i] = CntZero;
                    end
                end
                StPressWait: begin
                    if (!pressed[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = CntZero;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = CntZero;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StHeld: begin
                    if (!pressed[i]) begin
                        state_d[i] = StReleaseWait;
                        cnt_d[i]   = CntOne;
                    end
                end
                StReleaseWait: begin
                    if (pressed[i]) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = CntZero;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = CntZero;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = CntZero;
                end
            endcase
        end
    end

    // Output decode; the pulse is armed only on the PRESS_WAIT -> HELD transition.
    always_comb begin
        pulse_d = '0;
        held    = '0;
        for (int i = 0; i < NumCh; i++) begin
            pulse_d[i] = (state_q[i] == StPressWait) && pressed[i] && (cnt_q[i] == CntMax);
            held[i]    = (state_q[i] == StHeld) || (state_q[i] == StReleaseWait);
        end
    end

    assign UP        = pulse_q[0];
    assign DOWN      = pulse_q[1];
    assign up_held   = held[0];
    assign down_held = held[1];

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench for button_pulse_conditioner with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_button_pulse_conditioner;

    logic clock;
    logic reset;
    logic key_up;
    logic key_down;
    logic UP;
    logic DOWN;
    logic up_held;
    logic down_held;

    int edge_n = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int cyc;
        bit up;
        bit down;
    } pulse_t;

    typedef struct {
        int       cyc;
        bit [3:0] outs;   // {UP, DOWN, up_held, down_held}
    } snap_t;

    pulse_t pulse_q[$];
    snap_t  snap_q[$];

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_up   (key_up),
        .key_down (key_down),
        .UP       (UP),
        .DOWN     (DOWN),
        .up_held  (up_held),
        .down_held(down_held)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_pulse(input int c, input bit u, input bit d);
        pulse_t p;
        p.cyc  = c;
        p.up   = u;
        p.down = d;
        pulse_q.push_back(p);
    endtask

    task automatic push_snap(input int c, input bit u, input bit d, input bit uh, input bit dh);
        snap_t s;
        s.cyc  = c;
        s.outs = {u, d, uh, dh};
        snap_q.push_back(s);
    endtask

    // Monitor: compares every observed pulse and every scheduled output snapshot.
    always @(negedge clock) begin
        pulse_t p;
        snap_t  s;
        bit [3:0] act;
        act = {UP, DOWN, up_held, down_held};
        while (pulse_q.size() > 0 && pulse_q[0].cyc < edge_n) begin
            p = pulse_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL pulse_missing: expected up=%0b down=%0b at edge %0d, not observed by edge %0d",
                     p.up, p.down, p.cyc, edge_n);
        end
        if (UP || DOWN) begin
            compared++;
            if (pulse_q.size() == 0) begin
                mismatched++;
                $display("FAIL pulse_unexpected: got UP=%0b DOWN=%0b at edge %0d, required none",
                         UP, DOWN, edge_n);
            end else begin
                p = pulse_q.pop_front();
                if (p.cyc != edge_n || p.up != UP || p.down != DOWN) begin
                    mismatched++;
                    $display("FAIL pulse: got UP=%0b DOWN=%0b at edge %0d, required UP=%0b DOWN=%0b at edge %0d",
                             UP, DOWN, edge_n, p.up, p.down, p.cyc);
                end
            end
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= edge_n) begin
            s = snap_q.pop_front();
            compared++;
            if (s.cyc != edge_n || s.outs != act) begin
                mismatched++;
                $display("FAIL snapshot: {UP,DOWN,up_held,down_held} got %b at edge %0d, required %b at edge %0d",
                         act, edge_n, s.outs, s.cyc);
            end
        end
    end

    initial begin
        int k;
        reset    = 1'b1;
        key_up   = 1'b1;
        key_down = 1'b1;
        tick(2);
        push_snap(edge_n + 1, 0, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Clean press on up, then release
        k = edge_n;
        key_up = 1'b0;
        push_pulse(k + 6, 1, 0);
        push_snap(k + 5, 0, 0, 0, 0);
        push_snap(k + 6, 1, 0, 1, 0);
        push_snap(k + 7, 0, 0, 1, 0);
        tick(20);
        k = edge_n;
        key_up = 1'b1;
        push_snap(k + 5, 0, 0, 1, 0);
        push_snap(k + 6, 0, 0, 0, 0);
        tick(10);

        // Bounce on down: lows of 1, 2, 3 cycles are rejected
        k = edge_n;
        push_snap(k + 8, 0, 0, 0, 0);
        key_down = 1'b0; tick(1);
        key_down = 1'b1; tick(2);
        key_down = 1'b0; tick(2);
        key_down = 1'b1; tick(2);
        key_down = 1'b0; tick(3);
        key_down = 1'b1; tick(2);
        k = edge_n;
        key_down = 1'b0;
        push_pulse(k + 6, 0, 1);
        push_snap(k + 5, 0, 0, 0, 0);
        push_snap(k + 6, 0, 1, 0, 1);
        push_snap(k + 7, 0, 0, 0, 1);
        tick(10);
        k = edge_n;
        key_down = 1'b1;
        push_snap(k + 6, 0, 0, 0, 0);
        tick(10);

        // Release bounce while held
        k = edge_n;
        key_up = 1'b0;
        push_pulse(k + 6, 1, 0);
        push_snap(k + 6, 1, 0, 1, 0);
        tick(10);
        key_up = 1'b1;
        push_snap(k + 12, 0, 0, 1, 0);
        push_snap(k + 14, 0, 0, 1, 0);
        push_snap(k + 16, 0, 0, 1, 0);
        tick(2);
        key_up = 1'b0;
        tick(8);
        k = edge_n;
        key_up = 1'b1;
        push_snap(k + 5, 0, 0, 1, 0);
        push_snap(k + 6, 0, 0, 0, 0);
        tick(10);

        // Simultaneous press
        k = edge_n;
        key_up   = 1'b0;
        key_down = 1'b0;
        push_pulse(k + 6, 1, 1);
        push_snap(k + 6, 1, 1, 1, 1);
        push_snap(k + 7, 0, 0, 1, 1);
        tick(8);
        k = edge_n;
        key_up   = 1'b1;
        key_down = 1'b1;
        push_snap(k + 6, 0, 0, 0, 0);
        tick(10);

        // Reset mid-debounce, then mid-hold, key kept pressed throughout
        k = edge_n;
        key_up = 1'b0;
        tick(3);
        reset = 1'b1;
        push_snap(k + 4, 0, 0, 0, 0);
        push_snap(k + 5, 0, 0, 0, 0);
        push_snap(k + 6, 0, 0, 0, 0);
        push_snap(k + 10, 0, 0, 0, 0);
        tick(2);
        reset = 1'b0;
        push_pulse(k + 11, 1, 0);
        push_snap(k + 11, 1, 0, 1, 0);
        tick(10);
        reset = 1'b1;
        push_snap(k + 16, 0, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        push_pulse(k + 22, 1, 0);
        push_snap(k + 22, 1, 0, 1, 0);
        tick(10);
        k = edge_n;
        key_up = 1'b1;
        push_snap(k + 6, 0, 0, 0, 0);
        tick(10);

        // Long hold on down
        k = edge_n;
        key_down = 1'b0;
        push_pulse(k + 6, 0, 1);
        push_snap(k + 6, 0, 1, 0, 1);
        for (int i = 1; i <= 9; i++) push_snap(k + 100 * i, 0, 0, 0, 1);
        tick(1000);
        k = edge_n;
        key_down = 1'b1;
        push_snap(k + 5, 0, 0, 0, 1);
        push_snap(k + 6, 0, 0, 0, 0);
        tick(10);

        while (pulse_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL pulse_missing: expected pulse at edge %0d never seen", pulse_q[0].cyc);
            void'(pulse_q.pop_front());
        end
        while (snap_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL snapshot_missing: edge %0d never sampled", snap_q[0].cyc);
            void'(snap_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
